// File: rtl/sram_client_arbiter.sv
// Shares one Wishbone master port to SRAM between CPU, VGA and UART clients.
// VGA owns the bus while the display is (about to be) active; CPU/UART round-robin otherwise.
module sram_client_arbiter #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  vga_state,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  input  logic [3:0]  vga_sel,
  input  logic        uart_req,
  input  logic        uart_we,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_sel,
  output logic [31:0] client_rdata,
  output logic        cpu_ack,
  output logic        vga_ack,
  output logic        uart_ack,
  output logic        cpu_busy,
  output logic        vga_busy,
  output logic        uart_busy,
  output logic [1:0]  current_client,
  output logic        timeout_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  localparam logic [1:0] ID_CPU  = 2'd0;
  localparam logic [1:0] ID_VGA  = 2'd1;
  localparam logic [1:0] ID_UART = 2'd2;
  localparam logic [1:0] ID_NONE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;            // 0: CPU wins the next CPU/UART tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic          wb_stb_q, wb_stb_d;
  logic          wb_we_q, wb_we_d;
  logic [31:0]   wb_adr_q, wb_adr_d;
  logic [31:0]   wb_dat_o_q, wb_dat_o_d;
  logic [3:0]    wb_sel_q, wb_sel_d;
  logic [1:0]    cur_q, cur_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    ack_q, ack_d;          // {uart, vga, cpu}
  logic          tmo_q, tmo_d;

  logic vga_excl_s;
  logic cpu_elig_s;
  logic vga_elig_s;
  logic uart_elig_s;

  function automatic logic [2:0] owner_ack(input logic [1:0] id);
    case (id)
      ID_CPU:  owner_ack = 3'b001;
      ID_VGA:  owner_ack = 3'b010;
      ID_UART: owner_ack = 3'b100;
      default: owner_ack = 3'b000;
    endcase
  endfunction

  // A client whose ack is high this cycle is finishing, not asking again.
  assign vga_excl_s  = (vga_state == 2'd1) || (vga_state == 2'd2);
  assign vga_elig_s  = vga_req & ~ack_q[1];
  assign cpu_elig_s  = cpu_req & ~ack_q[0] & ~vga_excl_s;
  assign uart_elig_s = uart_req & ~ack_q[2] & ~vga_excl_s;

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    wb_cyc_d   = wb_cyc_q;
    wb_stb_d   = wb_stb_q;
    wb_we_d    = wb_we_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_o_d = wb_dat_o_q;
    wb_sel_d   = wb_sel_q;
    cur_d      = cur_q;
    rdata_d    = 32'h0000_0000;
    ack_d      = 3'b000;
    tmo_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (vga_elig_s) begin
          wb_we_d    = 1'b0;
          wb_adr_d   = vga_addr;
          wb_dat_o_d = 32'h0000_0000;
          wb_sel_d   = vga_sel;
          cur_d      = ID_VGA;
          wb_cyc_d   = 1'b1;
          wb_stb_d   = 1'b1;
          state_d    = ST_BUS;
        end else if (cpu_elig_s && (!rr_q || !uart_elig_s)) begin
          wb_we_d    = cpu_we;
          wb_adr_d   = cpu_addr;
          wb_dat_o_d = cpu_wdata;
          wb_sel_d   = cpu_sel;
          cur_d      = ID_CPU;
          wb_cyc_d   = 1'b1;
          wb_stb_d   = 1'b1;
          rr_d       = 1'b1;
          state_d    = ST_BUS;
        end else if (uart_elig_s) begin
          wb_we_d    = uart_we;
          wb_adr_d   = uart_addr;
          wb_dat_o_d = uart_wdata;
          wb_sel_d   = uart_sel;
          cur_d      = ID_UART;
          wb_cyc_d   = 1'b1;
          wb_stb_d   = 1'b1;
          rr_d       = 1'b0;
          state_d    = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // A late ack on the final wait cycle still completes normally.
        if (wb_ack) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          rdata_d  = wb_we_q ? 32'h0000_0000 : wb_dat_i;
          ack_d    = owner_ack(cur_q);
          cur_d    = ID_NONE;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          tmo_d    = 1'b1;
          ack_d    = owner_ack(cur_q);
          cur_d    = ID_NONE;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        wb_cyc_d = 1'b0;
        wb_stb_d = 1'b0;
        cur_d    = ID_NONE;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= 32'h0000_0000;
      wb_dat_o_q <= 32'h0000_0000;
      wb_sel_q   <= 4'h0;
      cur_q      <= ID_NONE;
      rdata_q    <= 32'h0000_0000;
      ack_q      <= 3'b000;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      wb_cyc_q   <= wb_cyc_d;
      wb_stb_q   <= wb_stb_d;
      wb_we_q    <= wb_we_d;
      wb_adr_q   <= wb_adr_d;
      wb_dat_o_q <= wb_dat_o_d;
      wb_sel_q   <= wb_sel_d;
      cur_q      <= cur_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      tmo_q      <= tmo_d;
    end
  end

  assign wb_cyc         = wb_cyc_q;
  assign wb_stb         = wb_stb_q;
  assign wb_we          = wb_we_q;
  assign wb_adr         = wb_adr_q;
  assign wb_dat_o       = wb_dat_o_q;
  assign wb_sel         = wb_sel_q;
  assign current_client = cur_q;
  assign client_rdata   = rdata_q;
  assign cpu_ack        = ack_q[0];
  assign vga_ack        = ack_q[1];
  assign uart_ack       = ack_q[2];
  assign timeout_err    = tmo_q;

  assign cpu_busy  = (cpu_req  & ~ack_q[0]) | (cur_q == ID_CPU);
  assign vga_busy  = (vga_req  & ~ack_q[1]) | (cur_q == ID_VGA);
  assign uart_busy = (uart_req & ~ack_q[2]) | (cur_q == ID_UART);

endmodule

// File: tb/tb_sram_client_arbiter.sv
// Scoreboard bench for sram_client_arbiter: clients and a Wishbone slave are modelled here,
// expected transactions are queued at issue time and compared at grant and at client ack.
module tb_sram_client_arbiter;

  logic        clk;
  logic        nrst;
  logic [1:0]  vga_state;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_sel;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic [3:0]  vga_sel;
  logic        uart_req, uart_we;
  logic [31:0] uart_addr, uart_wdata;
  logic [3:0]  uart_sel;
  logic [31:0] client_rdata;
  logic        cpu_ack, vga_ack, uart_ack;
  logic        cpu_busy, vga_busy, uart_busy;
  logic [1:0]  current_client;
  logic        timeout_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  sram_client_arbiter #(.MAX_WAIT(16)) dut (
    .clk(clk), .nrst(nrst), .vga_state(vga_state),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_sel(vga_sel),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_sel(uart_sel),
    .client_rdata(client_rdata), .cpu_ack(cpu_ack), .vga_ack(vga_ack), .uart_ack(uart_ack),
    .cpu_busy(cpu_busy), .vga_busy(vga_busy), .uart_busy(uart_busy),
    .current_client(current_client), .timeout_err(timeout_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  typedef struct {
    logic [1:0]  id;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] rd;
    int          len;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   slave_delay = 0;
  logic slave_mute = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    rd_fn = (a == 32'h0000_0020) ? 32'h0000_1234 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic push_exp(input logic [1:0] id, input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] sel, input int len, input logic tmo);
    exp_t e;
    e.id = id; e.we = we; e.adr = adr; e.wd = wd; e.sel = sel; e.len = len; e.tmo = tmo;
    e.rd = (tmo || we) ? 32'h0000_0000 : rd_fn(adr);
    sb.push_back(e);
  endtask

  // Client agent: raise req, hold until own ack, then drop it.
  task automatic issue(input logic [1:0] id, input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [3:0] sel);
    logic seen;
    seen = 1'b0;
    case (id)
      2'd0: begin cpu_we = we; cpu_addr = adr; cpu_wdata = wd; cpu_sel = sel; cpu_req = 1'b1; end
      2'd1: begin vga_addr = adr; vga_sel = sel; vga_req = 1'b1; end
      default: begin uart_we = we; uart_addr = adr; uart_wdata = wd; uart_sel = sel; uart_req = 1'b1; end
    endcase
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = (id == 2'd0) ? cpu_ack : (id == 2'd1) ? vga_ack : uart_ack;
    end
    case (id)
      2'd0: cpu_req = 1'b0;
      2'd1: vga_req = 1'b0;
      default: uart_req = 1'b0;
    endcase
    if (!seen) check_val("ack_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_cyc();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = wb_cyc;
    end
    if (!seen) check_val("cyc_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_sb(input int n);
    for (int i = 0; i < 600 && sb.size() > n; i++) @(negedge clk);
    if (sb.size() > n) check_val("drain_wait", 32'(sb.size()), 32'(n));
    repeat (2) @(negedge clk);
  endtask

  // Wishbone slave: acks after slave_delay wait cycles unless muted.
  initial begin
    int wait_n;
    wait_n = 0;
    wb_ack = 1'b0;
    wb_dat_i = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (!nrst || wb_ack) begin
        wb_ack = 1'b0;
        wait_n = 0;
      end else if (wb_cyc && wb_stb && !slave_mute) begin
        if (wait_n >= slave_delay) begin
          wb_ack = 1'b1;
          wb_dat_i = wb_we ? 32'hFFFF_FFFF : rd_fn(wb_adr);
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Monitor: compare grants against the scoreboard head, pop on client ack.
  initial begin
    logic prev_cyc;
    int   cyc_cnt;
    exp_t e;
    prev_cyc = 1'b0;
    cyc_cnt = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_cyc = 1'b0;
        cyc_cnt = 0;
      end else begin
        if (wb_cyc && !prev_cyc) begin
          cyc_cnt = 0;
          if (sb.size() == 0) begin
            check_val("grant_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            check_val("grant_client", 32'(current_client), 32'(e.id));
            check_val("grant_we", 32'(wb_we), 32'(e.we));
            check_val("grant_adr", wb_adr, e.adr);
            check_val("grant_sel", 32'(wb_sel), 32'(e.sel));
            check_val("grant_stb", 32'(wb_stb), 32'd1);
            if (e.we) check_val("grant_wdata", wb_dat_o, e.wd);
          end
        end
        if (wb_cyc) cyc_cnt++;
        if (cpu_ack || vga_ack || uart_ack) begin
          if (sb.size() == 0) begin
            check_val("ack_unexpected", {29'd0, uart_ack, vga_ack, cpu_ack}, 32'd0);
          end else begin
            e = sb.pop_front();
            check_val("ack_owner", {29'd0, uart_ack, vga_ack, cpu_ack}, 32'(3'b001 << e.id));
            check_val("ack_rdata", client_rdata, e.rd);
            check_val("ack_timeout_err", 32'(timeout_err), 32'(e.tmo));
            check_val("bus_cycles", 32'(cyc_cnt), 32'(e.len));
            check_val("ack_client_none", 32'(current_client), 32'd3);
            check_val("ack_cyc_low", 32'(wb_cyc), 32'd0);
          end
        end else if (timeout_err) begin
          check_val("timeout_stray", 32'(timeout_err), 32'd0);
        end
        prev_cyc = wb_cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; vga_state = 2'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_sel = 4'h0;
    vga_req = 1'b0; vga_addr = 32'h0; vga_sel = 4'h0;
    uart_req = 1'b0; uart_we = 1'b0; uart_addr = 32'h0; uart_wdata = 32'h0; uart_sel = 4'h0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_val("rst_client", 32'(current_client), 32'd3);
    check_val("rst_wb_ctl", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    check_val("rst_wb_adr", wb_adr, 32'd0);
    check_val("rst_wb_dat", wb_dat_o, 32'd0);
    check_val("rst_flags", {25'd0, wb_sel, cpu_ack, vga_ack, uart_ack}, 32'd0);
    check_val("rst_rdata", client_rdata, 32'd0);
    check_val("rst_tmo_busy", {28'd0, timeout_err, cpu_busy, vga_busy, uart_busy}, 32'd0);

    // CPU and UART both streaming: alternate starting with CPU.
    slave_delay = 0;
    push_exp(2'd0, 1'b1, 32'h0000_0100, 32'h1111_0001, 4'hF, 1, 1'b0);
    push_exp(2'd2, 1'b0, 32'h0000_0200, 32'h0, 4'h3, 1, 1'b0);
    push_exp(2'd0, 1'b0, 32'h0000_0104, 32'h0, 4'hC, 1, 1'b0);
    push_exp(2'd2, 1'b1, 32'h0000_0204, 32'h2222_0002, 4'h1, 1, 1'b0);
    fork
      begin
        issue(2'd0, 1'b1, 32'h0000_0100, 32'h1111_0001, 4'hF);
        issue(2'd0, 1'b0, 32'h0000_0104, 32'h0, 4'hC);
      end
      begin
        issue(2'd2, 1'b0, 32'h0000_0200, 32'h0, 4'h3);
        issue(2'd2, 1'b1, 32'h0000_0204, 32'h2222_0002, 4'h1);
      end
    join
    wait_sb(0);

    // Display active: VGA only, CPU/UART stall, then CPU before UART.
    vga_state = 2'd2;
    slave_delay = 1;
    push_exp(2'd1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 2, 1'b0);
    push_exp(2'd1, 1'b0, 32'h0000_0304, 32'h0, 4'hF, 2, 1'b0);
    push_exp(2'd0, 1'b1, 32'h0000_0400, 32'hCAFE_0001, 4'hF, 2, 1'b0);
    push_exp(2'd2, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 2, 1'b0);
    fork
      issue(2'd0, 1'b1, 32'h0000_0400, 32'hCAFE_0001, 4'hF);
      issue(2'd2, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
      begin
        issue(2'd1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        issue(2'd1, 1'b0, 32'h0000_0304, 32'h0, 4'hF);
      end
    join_none
    wait_sb(2);
    repeat (3) @(negedge clk);
    check_val("vga_stall_busy", {30'd0, cpu_busy, uart_busy}, 32'd3);
    check_val("vga_stall_idle", 32'(current_client), 32'd3);
    vga_state = 2'd0;
    wait_sb(0);

    // Single CPU write with zero-wait ack.
    slave_delay = 0;
    push_exp(2'd0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0);
    issue(2'd0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_sb(0);

    // vga_state rises during a UART read: UART completes, VGA next, CPU waits.
    slave_delay = 3;
    push_exp(2'd2, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 4, 1'b0);
    push_exp(2'd1, 1'b0, 32'h0000_0600, 32'h0, 4'h3, 4, 1'b0);
    push_exp(2'd0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'h5, 4, 1'b0);
    fork
      issue(2'd2, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
    join_none
    wait_cyc();
    vga_state = 2'd1;
    fork
      issue(2'd1, 1'b0, 32'h0000_0600, 32'h0, 4'h3);
      issue(2'd0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'h5);
    join_none
    wait_sb(1);
    repeat (3) @(negedge clk);
    check_val("rise_cpu_busy", 32'(cpu_busy), 32'd1);
    check_val("rise_cyc_low", 32'(wb_cyc), 32'd0);
    vga_state = 2'd3;
    wait_sb(0);
    vga_state = 2'd0;

    // No ack: abort after 16 bus cycles.
    slave_mute = 1'b1;
    push_exp(2'd0, 1'b0, 32'h0000_0050, 32'h0, 4'hF, 16, 1'b1);
    issue(2'd0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
    wait_sb(0);

    // Ack arriving on the final wait cycle is a normal completion.
    slave_mute = 1'b0;
    slave_delay = 15;
    push_exp(2'd2, 1'b0, 32'h0000_0060, 32'h0, 4'hF, 16, 1'b0);
    issue(2'd2, 1'b0, 32'h0000_0060, 32'h0, 4'hF);
    wait_sb(0);

    // Reset during BUS: bus drops at once, no ack, pointer back to CPU.
    slave_mute = 1'b1;
    slave_delay = 0;
    push_exp(2'd0, 1'b0, 32'h0000_0070, 32'h0, 4'hF, 1, 1'b0);
    cpu_we = 1'b0; cpu_addr = 32'h0000_0070; cpu_sel = 4'hF; cpu_req = 1'b1;
    wait_cyc();
    #2 nrst = 1'b0;
    #1;
    check_val("mid_rst_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check_val("mid_rst_client", 32'(current_client), 32'd3);
    check_val("mid_rst_ack", {29'd0, cpu_ack, vga_ack, uart_ack}, 32'd0);
    sb.delete();
    cpu_req = 1'b0;
    slave_mute = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    push_exp(2'd0, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'hF, 1, 1'b0);
    push_exp(2'd2, 1'b0, 32'h0000_0090, 32'h0, 4'hF, 1, 1'b0);
    fork
      issue(2'd2, 1'b0, 32'h0000_0090, 32'h0, 4'hF);
      issue(2'd0, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'hF);
    join
    wait_sb(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sram_client_arbiter.md
Name: sram_client_arbiter

Overview:
- Shares the single Wishbone path to SRAM between three clients: CPU (id 0), VGA (id 1) and UART (id 2).
- Sits between the clients and the Wishbone master port. Reports the owning client on `current_client`.
- Reserves the bus for the VGA engine while the display is about to be active or is active.
- Otherwise round-robins between CPU and UART. Runs one transaction at a time, with an ack timeout.

Parameters:
- MAX_WAIT, 16: cycles with `wb_cyc` high and no `wb_ack` before the transaction is aborted.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- vga_state  in  2  0 = inactive, 1 = about to be active, 2 = active, 3 treated as 0
- cpu_req  in  1  CPU request
- cpu_we  in  1  CPU write enable
- cpu_addr  in  32  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_sel  in  4  CPU byte select
- vga_req  in  1  VGA request (read only)
- vga_addr  in  32  VGA word address
- vga_sel  in  4  VGA byte select
- uart_req  in  1  UART request
- uart_we  in  1  UART write enable
- uart_addr  in  32  UART word address
- uart_wdata  in  32  UART write data
- uart_sel  in  4  UART byte select
- client_rdata  out  32  read data, valid in the cycle the client's ack is high
- cpu_ack, vga_ack, uart_ack  out  1 each  one-cycle completion pulse
- cpu_busy, vga_busy, uart_busy  out  1 each  the client's request is pending or in flight
- current_client  out  2  0 = CPU, 1 = VGA, 2 = UART, 3 = none
- timeout_err  out  1  one-cycle pulse on abort
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone controls
- wb_adr  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel  out  4  Wishbone byte select
- wb_dat_i  in  32  Wishbone read data
- wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset (async, nrst low):
  - State = IDLE, `current_client` = 3.
  - All wb_* outputs, acks, `timeout_err` and `client_rdata` = 0.
  - Round-robin pointer favours CPU next; wait counter = 0.
- Reset mid-transaction aborts immediately. No ack is issued.
- Two-state FSM, IDLE and BUS. All outputs except *_busy are registered.
- IDLE arbitration, evaluated every cycle:
  - When `vga_state` is 1 or 2, only VGA is eligible. CPU and UART stall (busy stays high).
  - Otherwise the priority is VGA, then the round-robin winner between CPU and UART.
  - The pointer flips to the other requester after each CPU or UART grant.
  - Grant at edge N: the winner's we/addr/wdata/sel are latched into the wb_* registers.
  - At the same edge, `wb_cyc` and `wb_stb` are set to 1, `current_client` is set to the winner id, and the state moves to BUS.
  - VGA grants force `wb_we` = 0.
- BUS:
  - Hold the wb_* outputs stable. The wait counter increments each cycle.
  - On `wb_ack`:
    - Drop `wb_cyc` and `wb_stb`.
    - Register `wb_dat_i` into `client_rdata` (0 for writes).
    - Pulse the owner's ack for exactly one cycle. Return to IDLE with `current_client` = 3 and the counter cleared.
    - Client ack therefore follows `wb_ack` by one cycle.
    - IDLE spends at least one cycle before the next grant.
  - On counter == MAX_WAIT-1 with no `wb_ack`:
    - Drop the bus and pulse `timeout_err`.
    - Pulse the owner's ack with `client_rdata` = 0, then return to IDLE.
  - A `wb_ack` on the timeout cycle counts as a normal completion; `timeout_err` stays 0.
- Minimum request-to-ack latency: request seen at edge N, Wishbone active from N, with zero-wait `wb_ack` sampled at N+1, client ack high in cycle N+2.
- No preemption:
  - A `vga_state` rise during a CPU/UART transaction does not abort it. The next grant goes to VGA.
  - Dropping req during BUS does not abort; the ack still pulses.
  - Dropping req while waiting in IDLE withdraws the request.
- busy (combinational): x_busy = x_req & ~x_ack, or x owns the bus.
- `wb_ack` while in IDLE is ignored.

Test Plan:
- Single CPU write, addr 0x10, data 0xDEADBEEF, sel 4'hF, `wb_ack` one cycle after `wb_cyc` -> `wb_adr`=0x10, `wb_we`=1, `current_client`=0; `cpu_ack` pulses 1 cycle after `wb_ack`; `current_client` back to 3.
- CPU and UART requesting continuously, `vga_state`=0, 4 transactions -> grant order CPU, UART, CPU, UART, with `wb_cyc` low for ≥1 cycle between.
- `vga_state`=2 with CPU, UART and VGA requesting -> only VGA granted, each with `wb_we`=0. CPU/UART busy stays 1 until `vga_state`=0, then CPU is granted first.
- `vga_state` rises to 1 while a UART read is in BUS; `wb_ack` returns 0x1234 -> `uart_ack`, `client_rdata`=0x1234; next grant is VGA.
- No `wb_ack` for a CPU read -> after 16 cycles the bus drops, `timeout_err`=1, `cpu_ack`=1 with `client_rdata`=0, all for one cycle.
- nrst low during BUS -> `wb_cyc`=0 and `current_client`=3 immediately with no ack; after release, the first CPU/UART grant goes to CPU.
